// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter sequencing one valid/ready bus transaction at a time with timeout
module bus_arbiter #(
  parameter int TIMEOUT = 16,
  parameter logic [1:0] FETCH_HB = 2'b10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_hb_i,
  input  logic [31:0] m1_wdata_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        bus_valid_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_we_o,
  output logic [1:0]  bus_hb_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ready_i
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic last_q, last_d, gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic we_q, we_d;
  logic [1:0] hb_q, hb_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic pick1, done;
  logic [31:0] rd;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    gnt_d = gnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    hb_d = hb_q;
    m0_rdata_d = m0_rdata_q;
    m0_err_d = m0_err_q;
    m1_rdata_d = m1_rdata_q;
    m1_err_d = m1_err_q;
    pick1 = m1_req_i && (!m0_req_i || !last_q);
    done = bus_ready_i || cnt_q == CNT_LAST;
    rd = bus_ready_i ? bus_rdata_i : '0;
    case (state_q)
      IDLE:
        if (m0_req_i || m1_req_i) begin
          gnt_d = pick1;
          last_d = pick1;
          addr_d = pick1 ? m1_addr_i : m0_addr_i;
          wdata_d = pick1 ? m1_wdata_i : '0;
          we_d = pick1 && m1_we_i;
          hb_d = pick1 ? m1_hb_i : FETCH_HB;
          cnt_d = '0;
          state_d = ACCESS;
        end
      ACCESS:
        if (done) begin
          m0_rdata_d = gnt_q ? m0_rdata_q : rd;
          m0_err_d = gnt_q ? m0_err_q : !bus_ready_i;
          m1_rdata_d = gnt_q ? rd : m1_rdata_q;
          m1_err_d = gnt_q ? !bus_ready_i : m1_err_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      RESP: begin
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= 1'b0;
      gnt_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      hb_q <= '0;
      m0_rdata_q <= '0;
      m0_err_q <= 1'b0;
      m1_rdata_q <= '0;
      m1_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      hb_q <= hb_d;
      m0_rdata_q <= m0_rdata_d;
      m0_err_q <= m0_err_d;
      m1_rdata_q <= m1_rdata_d;
      m1_err_q <= m1_err_d;
    end
  end
  assign bus_valid_o = state_q == ACCESS;
  assign bus_addr_o = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_we_o = we_q;
  assign bus_hb_o = hb_q;
  assign m0_ack_o = state_q == RESP && !gnt_q;
  assign m1_ack_o = state_q == RESP && gnt_q;
  assign m0_rdata_o = m0_rdata_q;
  assign m1_rdata_o = m1_rdata_q;
  assign m0_err_o = m0_err_q;
  assign m1_err_o = m1_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed vectors with hand-computed expectations for bus_arbiter
module tb_bus_arbiter;
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic m0_req_i = 1'b0, m1_req_i = 1'b0, m1_we_i = 1'b0, bus_ready_i = 1'b0;
  logic [31:0] m0_addr_i = '0, m1_addr_i = '0, m1_wdata_i = '0, bus_rdata_i = '0;
  logic [1:0] m1_hb_i = '0;
  logic [31:0] m0_rdata_o, m1_rdata_o, bus_addr_o, bus_wdata_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, bus_valid_o, bus_we_o;
  logic [1:0] bus_hb_o;
  int compared = 0, mismatched = 0;
  bus_arbiter #(.TIMEOUT(4), .FETCH_HB(2'b10)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_hb_i(m1_hb_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .bus_valid_o(bus_valid_o), .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_we_o(bus_we_o),
    .bus_hb_o(bus_hb_o), .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    tick;
    tick;
    check("rst_valid", 32'(bus_valid_o), 0);
    check("rst_ack0", 32'(m0_ack_o), 0);
    check("rst_ack1", 32'(m1_ack_o), 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_rdata0", m0_rdata_o, 0);
    rst_i = 1'b0;
    m0_req_i = 1'b1;
    m0_addr_i = 32'h10;
    tick;
    check("f_valid", 32'(bus_valid_o), 1);
    check("f_addr", bus_addr_o, 32'h10);
    check("f_we", 32'(bus_we_o), 0);
    check("f_hb", 32'(bus_hb_o), 2);
    check("f_wdata", bus_wdata_o, 0);
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h12345678;
    tick;
    check("f_ack", 32'(m0_ack_o), 1);
    check("f_ack1", 32'(m1_ack_o), 0);
    check("f_rdata", m0_rdata_o, 32'h12345678);
    check("f_err", 32'(m0_err_o), 0);
    check("f_valid_off", 32'(bus_valid_o), 0);
    m0_req_i = 1'b0;
    bus_ready_i = 1'b0;
    tick;
    check("f_ack_once", 32'(m0_ack_o), 0);
    check("f_rdata_hold", m0_rdata_o, 32'h12345678);
    m1_req_i = 1'b1;
    m1_we_i = 1'b1;
    m1_hb_i = 2'b00;
    m1_addr_i = 32'h104;
    m1_wdata_i = 32'hAB;
    tick;
    m1_addr_i = 32'hDEAD;
    m1_wdata_i = 32'hBEEF;
    m1_we_i = 1'b0;
    m1_hb_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      check("s_valid", 32'(bus_valid_o), 1);
      check("s_addr", bus_addr_o, 32'h104);
      check("s_wdata", bus_wdata_o, 32'hAB);
      check("s_we", 32'(bus_we_o), 1);
      check("s_hb", 32'(bus_hb_o), 0);
      check("s_noack", 32'(m1_ack_o), 0);
      if (i == 2) begin
        bus_ready_i = 1'b1;
        bus_rdata_i = 32'h77;
      end
      tick;
    end
    check("s_ack", 32'(m1_ack_o), 1);
    check("s_ack0", 32'(m0_ack_o), 0);
    check("s_rdata", m1_rdata_o, 32'h77);
    check("s_err", 32'(m1_err_o), 0);
    m1_req_i = 1'b0;
    bus_ready_i = 1'b0;
    tick;
    check("s_ack_once", 32'(m1_ack_o), 0);
    rst_i = 1'b1;
    m0_req_i = 1'b1;
    m0_addr_i = 32'hA0;
    m1_req_i = 1'b1;
    m1_addr_i = 32'hB0;
    m1_we_i = 1'b0;
    m1_hb_i = 2'b01;
    tick;
    rst_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick;
      check("c_valid", 32'(bus_valid_o), 1);
      check("c_addr", bus_addr_o, (t % 2 == 0) ? 32'hB0 : 32'hA0);
      check("c_hb", 32'(bus_hb_o), (t % 2 == 0) ? 32'd1 : 32'd2);
      bus_ready_i = 1'b1;
      bus_rdata_i = 32'(t + 1);
      tick;
      check("c_ack1", 32'(m1_ack_o), (t % 2 == 0) ? 32'd1 : 32'd0);
      check("c_ack0", 32'(m0_ack_o), (t % 2 == 0) ? 32'd0 : 32'd1);
      check("c_rdata", (t % 2 == 0) ? m1_rdata_o : m0_rdata_o, 32'(t + 1));
      bus_ready_i = 1'b0;
      tick;
      check("c_idle_acks", 32'({m0_ack_o, m1_ack_o}), 0);
    end
    m0_req_i = 1'b0;
    m1_addr_i = 32'h300;
    m1_hb_i = 2'b10;
    tick;
    check("t_addr", bus_addr_o, 32'h300);
    for (int i = 0; i < 4; i++) begin
      check("t_valid", 32'(bus_valid_o), 1);
      check("t_noack", 32'(m1_ack_o), 0);
      tick;
    end
    check("t_valid_off", 32'(bus_valid_o), 0);
    check("t_ack", 32'(m1_ack_o), 1);
    check("t_err", 32'(m1_err_o), 1);
    check("t_rdata", m1_rdata_o, 0);
    m1_req_i = 1'b0;
    tick;
    m1_req_i = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      check("r_valid", 32'(bus_valid_o), 1);
      tick;
    end
    check("r_valid4", 32'(bus_valid_o), 1);
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h55;
    tick;
    check("r_ack", 32'(m1_ack_o), 1);
    check("r_err", 32'(m1_err_o), 0);
    check("r_rdata", m1_rdata_o, 32'h55);
    m1_req_i = 1'b0;
    bus_ready_i = 1'b0;
    tick;
    m0_req_i = 1'b1;
    m0_addr_i = 32'h40;
    tick;
    check("m_valid", 32'(bus_valid_o), 1);
    rst_i = 1'b1;
    tick;
    check("m_valid_off", 32'(bus_valid_o), 0);
    check("m_noack", 32'({m0_ack_o, m1_ack_o}), 0);
    rst_i = 1'b0;
    tick;
    check("m_noack2", 32'({m0_ack_o, m1_ack_o}), 0);
    check("m_regrant", 32'(bus_valid_o), 1);
    check("m_addr", bus_addr_o, 32'h40);
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'h99;
    tick;
    check("m_ack", 32'(m0_ack_o), 1);
    check("m_rdata", m0_rdata_o, 32'h99);
    m0_req_i = 1'b0;
    bus_ready_i = 1'b0;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer for the shared core memory bus.
- Master 0 is instruction fetch (read-only); master 1 is the load/store unit (read/write, byte/half/word mode).
- Grants one transaction at a time with round-robin tie-break, drives the bus address/data/mode lines with a valid/ready handshake, and returns read data or a timeout error to the granted master.
- Sits between the core ports and the address decoder / chip-select logic that fronts ROM, RAM, UART and RAMIO.

Parameters:
- TIMEOUT, 16, number of ACCESS cycles without bus_ready_i before the transaction is aborted with error (legal range 1..255).
- FETCH_HB, 2'b10, mode value driven on bus_hb_o for master-0 fetches (word).

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  fetch request, held until m0_ack_o
- m0_addr_i  in  32  fetch address
- m0_rdata_o  out  32  fetch read data, valid while m0_ack_o=1
- m0_ack_o  out  1  one-cycle completion pulse to master 0
- m0_err_o  out  1  timeout flag, qualified by m0_ack_o
- m1_req_i  in  1  load/store request, held until m1_ack_o
- m1_addr_i  in  32  load/store address
- m1_we_i  in  1  write enable
- m1_hb_i  in  2  byte/half/word mode
- m1_wdata_i  in  32  write data
- m1_rdata_o  out  32  load data, valid while m1_ack_o=1
- m1_ack_o  out  1  one-cycle completion pulse to master 1
- m1_err_o  out  1  timeout flag, qualified by m1_ack_o
- bus_valid_o  out  1  transaction in progress on the bus
- bus_addr_o  out  32  registered address
- bus_wdata_o  out  32  registered write data
- bus_we_o  out  1  registered write enable (always 0 for master 0)
- bus_hb_o  out  2  registered mode
- bus_rdata_i  in  32  read data from decoded slave
- bus_ready_i  in  1  slave completion, sampled only while bus_valid_o=1

Behaviour:
- One clock (clk_i). Reset is synchronous, active-high (rst_i); the polarity and synchronicity are fixed.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - The timeout counter clears and last_grant is set to 0 (master 0), so the first tie goes to master 1.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - One request pending: grant that master.
  - Both pending: grant the master that is not last_grant. Update last_grant on every grant.
  - On grant, register addr/wdata/we/hb into the bus_* outputs. Master 0 takes we=0, hb=FETCH_HB, wdata=0.
  - Go to ACCESS with bus_valid_o=1 from the next cycle. No request: stay in IDLE.
- ACCESS:
  - bus_* outputs are held stable; master inputs are ignored after the grant.
  - bus_ready_i=1 at an edge: capture bus_rdata_i into the granted master's rdata register (also on writes), clear err, drop bus_valid_o, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without ready: set rdata=0 and err=1, drop bus_valid_o, go to RESP.
  - bus_ready_i arriving in the same cycle as the timeout wins (normal completion).
- RESP:
  - The granted master's ack is 1 for exactly one cycle with rdata/err valid; the other master's ack stays 0.
  - No arbitration happens in RESP. Return to IDLE and clear the counter.
  - A master that keeps req high after ack is treated as a new request in IDLE.
- Latency: request seen in IDLE at edge N gives bus_valid_o high N+1. Ready at N+1 gives ack at N+2. Minimum 3 cycles per transaction; back-to-back throughput 1 transaction per 3 cycles plus wait states.
- rdata/err outputs hold their value outside ack; they are qualified by ack only.
- A request dropped before grant is lost silently. A request dropped after grant does not cancel the bus transaction; the ack still pulses.
- Reset in ACCESS or RESP: return to IDLE at that edge, bus_valid_o=0 and ack=0 at the next cycle, no ack is issued for the aborted transaction.

Test Plan:
- Single fetch: m0_req_i=1, addr=0x00000010; slave ready 1 cycle after valid with rdata=0x12345678 -> bus_addr_o=0x10, bus_we_o=0, bus_hb_o=2'b10; m0_ack_o pulses once with m0_rdata_o=0x12345678, m0_err_o=0.
- Store with wait states: m1 we=1, hb=2'b00, addr=0x104, wdata=0xAB; ready after 3 cycles -> bus_* stable for all 3 cycles; m1_ack_o pulses one cycle after ready; m0_ack_o stays 0.
- Contention: both req held from reset for 4 transactions -> grant order m1, m0, m1, m0; exactly one ack per transaction, never both acks in the same cycle.
- Timeout: TIMEOUT=4, m1 load addr=0x300, ready never asserted -> bus_valid_o high for exactly 4 cycles, then m1_ack_o=1, m1_err_o=1, m1_rdata_o=0.
- Ready on timeout cycle: TIMEOUT=4, ready asserted on the 4th valid cycle with rdata=0x55 -> err=0, rdata=0x55.
- Mid-op reset: rst_i=1 during ACCESS -> next cycle bus_valid_o=0, no ack; after release, a pending m0 request is granted normally.
